// File: rtl/fft_out_checker.sv
// fft_out_checker: streams FFT output samples over a valid/ready handshake,
// fetches the matching golden word from a one-cycle-latency ROM and reports
// a registered per-frame verdict (done/pass/frame_err/err_cnt/first_err_idx).
// Optional feature macro: FFT_CHK_TOL_EN enables a per-component absolute
// tolerance (TOL) on the signed {re, im} halves instead of exact equality.
//
// Handshake: a sample transfers in a cycle where in_valid and in_ready are
// both high (acc). in_ready is high only in RUN and does not depend on
// in_valid; the producer must hold in_data/in_last stable until accepted.
module fft_out_checker #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int TOL        = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic                  done,
   output logic                  pass,
   output logic                  frame_err,
   output logic [ADDR_WIDTH:0]   err_cnt,
   output logic [ADDR_WIDTH-1:0] first_err_idx,
   output logic [1:0]            dbg_state
);

   localparam int                  H        = DATA_WIDTH / 2;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH:0]   CNT_MAX  = {(ADDR_WIDTH+1){1'b1}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                  state, state_n;
   logic [ADDR_WIDTH-1:0]   idx, idx_n;
   logic [ADDR_WIDTH:0]     err_cnt_n;
   logic [ADDR_WIDTH-1:0]   first_err_idx_n;
   logic                    frame_err_n, done_n, pass_n;
   logic                    acc;
   logic                    mismatch;

   assign in_ready  = (state == RUN);
   assign acc       = in_valid & in_ready;
   // Prefetch the next golden word on an accept so back-to-back samples
   // each find their reference on rom_data the following cycle.
   assign rom_addr  = acc ? idx + 1'b1 : idx;
   assign dbg_state = state;

`ifdef FFT_CHK_TOL_EN
   localparam logic [H:0] TOL_V = (H+1)'(TOL);
   logic signed [H:0] re_diff, im_diff;
   logic [H:0]        re_abs, im_abs;

   // Sign-extend each half by one bit so the difference cannot overflow.
   always_comb begin
      re_diff = {in_data[DATA_WIDTH-1], in_data[DATA_WIDTH-1:H]}
              - {rom_data[DATA_WIDTH-1], rom_data[DATA_WIDTH-1:H]};
      im_diff = {in_data[H-1], in_data[H-1:0]}
              - {rom_data[H-1], rom_data[H-1:0]};
      re_abs  = re_diff[H] ? $unsigned(-re_diff) : $unsigned(re_diff);
      im_abs  = im_diff[H] ? $unsigned(-im_diff) : $unsigned(im_diff);
   end

   assign mismatch = (re_abs > TOL_V) || (im_abs > TOL_V);
`else
   localparam int unused_tol = TOL;
   assign mismatch = (in_data != rom_data);
`endif

   // State and statistics registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         idx           <= '0;
         err_cnt       <= '0;
         first_err_idx <= '0;
         frame_err     <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
      end else begin
         state         <= state_n;
         idx           <= idx_n;
         err_cnt       <= err_cnt_n;
         first_err_idx <= first_err_idx_n;
         frame_err     <= frame_err_n;
         done          <= done_n;
         pass          <= pass_n;
      end
   end

   // Next-state, compare accounting and verdict computation.
   always_comb begin
      state_n         = state;
      idx_n           = idx;
      err_cnt_n       = err_cnt;
      first_err_idx_n = first_err_idx;
      frame_err_n     = frame_err;
      done_n          = done;
      pass_n          = pass;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               idx_n           = '0;
               err_cnt_n       = '0;
               first_err_idx_n = '0;
               frame_err_n     = 1'b0;
               done_n          = 1'b0;
               pass_n          = 1'b0;
               state_n         = PRIME;
            end
         end
         PRIME: begin
            state_n = RUN;
         end
         RUN: begin
            if (acc) begin
               if (mismatch) begin
                  if (err_cnt != CNT_MAX) err_cnt_n = err_cnt + 1'b1;
                  if (err_cnt == '0)      first_err_idx_n = idx;
               end
               if (in_last || idx == LAST_IDX) begin
                  // Length error unless in_last lands exactly on the final index.
                  if (!(in_last && idx == LAST_IDX)) frame_err_n = 1'b1;
                  state_n = DONE;
                  done_n  = 1'b1;
                  pass_n  = (err_cnt_n == '0) && !frame_err_n;
               end else begin
                  idx_n = idx + 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: doc/fft_out_checker.md
# fft_out_checker

Streaming checker downstream of the golden FFT-output ROM in the burst FFT/IFFT apply bench. It drives the ROM read address, absorbs the ROM's one-cycle read latency, and compares each FFT output sample accepted on a valid/ready stream against the matching golden word. It accumulates mismatch statistics and frame-length errors, then reports a registered pass/fail verdict per frame.

## Interface
- ADDR_WIDTH, 10, ROM address width; frame length DEPTH = 2**ADDR_WIDTH samples
- DATA_WIDTH, 32, sample width, packed {re, im}, each half DATA_WIDTH/2 bits signed; must be even
- TOL, 0, per-component absolute tolerance; used only with FFT_CHK_TOL_EN
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin checking one frame; single-cycle pulse
- in_valid  in  1  FFT output sample valid
- in_ready  out  1  checker accepts the sample this cycle
- in_data  in  DATA_WIDTH  FFT output sample
- in_last  in  1  final sample of the frame
- rom_addr  out  ADDR_WIDTH  ROM read address; combinational from internal index and handshake
- rom_data  in  DATA_WIDTH  ROM read data; valid one cycle after rom_addr
- done  out  1  frame check complete; level signal
- pass  out  1  done, zero mismatches, no frame error
- frame_err  out  1  in_last position did not match DEPTH
- err_cnt  out  ADDR_WIDTH+1  mismatch count; saturates at all-ones
- first_err_idx  out  ADDR_WIDTH  index of the first mismatching sample; 0 when none

## Operation
- Registered sample index idx (ADDR_WIDTH bits). Handshake acc = in_valid & in_ready.
- rom_addr = acc ? idx+1 : idx. This prefetches the next golden word so back-to-back samples check at one per cycle.
- FSM states and transitions:
  - IDLE: on start, clear idx, err_cnt, first_err_idx, frame_err, done, pass; go to PRIME.
  - PRIME: one cycle; rom_addr=0 so rom_data holds mem[0] in the next cycle; go to RUN.
  - RUN: in_ready=1. On acc, compare in_data against rom_data.
    - On mismatch, increment err_cnt (saturating). If err_cnt was 0, capture first_err_idx=idx.
    - If in_last and idx==DEPTH-1: go to DONE.
    - If in_last and idx<DEPTH-1: set frame_err, go to DONE (short frame).
    - If no in_last and idx==DEPTH-1: set frame_err, go to DONE (long frame).
    - Otherwise idx<=idx+1.
  - DONE: done=1; pass=(err_cnt==0)&&!frame_err. On start, clear everything and go to PRIME.
- start is ignored in PRIME and RUN.
- The sample accepted in the cycle that enters DONE is fully compared, including its mismatch and frame_err effects.
- Mismatch compare is exact equality unless FFT_CHK_TOL_EN is defined.

## Timing
- Reset values: in_ready 0, rom_addr 0, done 0, pass 0, frame_err 0, err_cnt 0, first_err_idx 0, state IDLE, idx 0.
- start at cycle T: PRIME at T+1, in_ready=1 from T+2.
- Sustained throughput: one sample per cycle with in_valid held high.
- Final sample accepted at cycle N: done and pass valid from N+1 and held until the next start or reset.
- in_valid low in RUN: idx and rom_addr hold, and rom_data stays on the expected word.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous). No partial verdict is kept.

## Configuration
- FFT_CHK_TOL_EN defined: split in_data and rom_data into signed re/im halves. A sample matches when |re_in-re_gold|<=TOL and |im_in-im_gold|<=TOL. Differences are computed at DATA_WIDTH/2+1 bits so no overflow occurs.
- FFT_CHK_TOL_EN undefined: a sample matches only when in_data==rom_data; TOL is unused.

## Test plan
- Full match: ADDR_WIDTH=4, 16 golden samples streamed back-to-back, in_last on sample 15 -> done=1 one cycle later, pass=1, err_cnt=0, frame_err=0.
- Two corrupted samples at indices 3 and 9 -> err_cnt=2, first_err_idx=3, pass=0.
- Short frame, in_last on index 7 -> frame_err=1, done=1, pass=0. Long frame, no in_last through index 15 -> frame_err=1, DONE entered after index 15.
- Random in_valid gaps (50% duty) with correct data -> pass=1. rom_addr equals the accepted index+1 in each accept cycle and holds otherwise.
- Reset pulled low at sample 6, then released, then start with a clean frame -> all outputs 0 during reset, then pass=1.
- FFT_CHK_TOL_EN with TOL=1: re off by +1 -> match; im off by -2 -> err_cnt=1.
